jtag_dtm: RTL and testbench

Parametrised JTAG Debug Transport Module (RISC-V Debug Spec 0.13 DTM) for the debug subsystem. It runs the IEEE 1149.1 TAP, exposes the IDCODE, DTMCS, DMI and BYPASS registers, and turns DMI scans into valid/ready requests toward the Debug Module. Compared with the previous generation it adds:
- configurable IR length and address width;
- a real request/response handshake with outstanding-request tracking;
- sticky dmistat error codes;
- dmireset and dmihardreset.

---
 rtl/jtag_dtm.sv | 227 ++++++++++++++++++++++
 tb/tb_jtag_dtm.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dtm.sv
`timescale 1ns/1ps
// jtag_dtm: RISC-V Debug 0.13 JTAG Debug Transport Module.
// Runs the IEEE 1149.1 TAP. Exposes the IDCODE, DTMCS, DMI and BYPASS data registers.
// DMI scans become valid/ready requests toward the Debug Module, with one outstanding
// request tracked by pending_reg. dmistat error codes are sticky.
// Optional build macro JTAG_DTM_USERCODE_EN adds a 32-bit USERCODE register.
// When the macro is undefined, instruction 'h03 is treated as BYPASS.
module jtag_dtm #(
    parameter int          IR_BITS        = 5,
    parameter int          ABITS          = 6,
    parameter logic [31:0] IDCODE_VALUE   = 32'h1E200A6F,
    parameter logic [2:0]  IDLE_HINT      = 3'd5,
    parameter int          IR_IDCODE      = 'h01,
    parameter int          IR_DTMCS       = 'h10,
    parameter int          IR_DMI         = 'h11
`ifdef JTAG_DTM_USERCODE_EN
    ,
    parameter logic [31:0] USERCODE_VALUE = 32'h0,
    parameter int          IR_USERCODE    = 'h03
`endif
) (
    input  logic              jtag_TCK,
    input  logic              rst_n,
    input  logic              jtag_TMS,
    input  logic              jtag_TDI,
    output logic              jtag_TDO,
    output logic              dtm_req_valid,
    input  logic              dtm_req_ready,
    output logic [ABITS+33:0] dtm_req_data,
    input  logic              dm_resp_valid,
    input  logic [ABITS+33:0] dm_resp_data,
    output logic              dmi_hardreset
);
    localparam int DRW = ABITS + 34;

    localparam logic [IR_BITS-1:0] IR_IDCODE_C = IR_BITS'(IR_IDCODE);
    localparam logic [IR_BITS-1:0] IR_DTMCS_C  = IR_BITS'(IR_DTMCS);
    localparam logic [IR_BITS-1:0] IR_DMI_C    = IR_BITS'(IR_DMI);
`ifdef JTAG_DTM_USERCODE_EN
    localparam logic [IR_BITS-1:0] IR_USER_C   = IR_BITS'(IR_USERCODE);
`endif

    localparam logic [3:0] ST_TEST_LOGIC_RESET = 4'd0;
    localparam logic [3:0] ST_RUN_TEST_IDLE    = 4'd1;
    localparam logic [3:0] ST_SELECT_DR        = 4'd2;
    localparam logic [3:0] ST_CAPTURE_DR       = 4'd3;
    localparam logic [3:0] ST_SHIFT_DR         = 4'd4;
    localparam logic [3:0] ST_EXIT1_DR         = 4'd5;
    localparam logic [3:0] ST_PAUSE_DR         = 4'd6;
    localparam logic [3:0] ST_EXIT2_DR         = 4'd7;
    localparam logic [3:0] ST_UPDATE_DR        = 4'd8;
    localparam logic [3:0] ST_SELECT_IR        = 4'd9;
    localparam logic [3:0] ST_CAPTURE_IR       = 4'd10;
    localparam logic [3:0] ST_SHIFT_IR         = 4'd11;
    localparam logic [3:0] ST_EXIT1_IR         = 4'd12;
    localparam logic [3:0] ST_PAUSE_IR         = 4'd13;
    localparam logic [3:0] ST_EXIT2_IR         = 4'd14;
    localparam logic [3:0] ST_UPDATE_IR        = 4'd15;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    logic [3:0]         state_reg;
    logic [3:0]         state_next;
    logic [IR_BITS-1:0] ir_reg;
    logic [IR_BITS-1:0] ir_shift_reg;
    logic [DRW-1:0]     dr_shift_reg;
    logic [DRW-1:0]     dr_capture;
    logic [DRW-1:0]     dr_shifted;
    logic [6:0]         dr_last;
    logic [1:0]         dmistat_reg;
    logic               pending_reg;
    logic [DRW-1:0]     resp_reg;
    logic               sel_idcode;
    logic               sel_dtmcs;
    logic               sel_dmi;
    logic               sel_32;

    assign sel_idcode = (ir_reg == IR_IDCODE_C);
    assign sel_dtmcs  = (ir_reg == IR_DTMCS_C);
    assign sel_dmi    = (ir_reg == IR_DMI_C);
`ifdef JTAG_DTM_USERCODE_EN
    logic sel_user;
    assign sel_user   = (ir_reg == IR_USER_C);
    assign sel_32     = sel_idcode | sel_dtmcs | sel_user;
`else
    assign sel_32     = sel_idcode | sel_dtmcs;
`endif

    // Standard TAP next-state table driven by TMS
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_TEST_LOGIC_RESET: state_next = jtag_TMS ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
            ST_RUN_TEST_IDLE:    state_next = jtag_TMS ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
            ST_SELECT_DR:        state_next = jtag_TMS ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR:       state_next = jtag_TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR:         state_next = jtag_TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR:         state_next = jtag_TMS ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:         state_next = jtag_TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR:         state_next = jtag_TMS ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:        state_next = jtag_TMS ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
            ST_SELECT_IR:        state_next = jtag_TMS ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
            ST_CAPTURE_IR:       state_next = jtag_TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR:         state_next = jtag_TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR:         state_next = jtag_TMS ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:         state_next = jtag_TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR:         state_next = jtag_TMS ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:        state_next = jtag_TMS ? ST_SELECT_DR : ST_RUN_TEST_IDLE;
        endcase
    end

    // TAP state register
    always_ff @(posedge jtag_TCK) begin
        if (!rst_n) state_reg <= ST_TEST_LOGIC_RESET;
        else        state_reg <= state_next;
    end

    // Instruction register. Test-Logic-Reset always selects IDCODE.
    always_ff @(posedge jtag_TCK) begin
        if (!rst_n) begin
            ir_reg       <= IR_IDCODE_C;
            ir_shift_reg <= '0;
        end else begin
            if (state_reg == ST_TEST_LOGIC_RESET) ir_reg <= IR_IDCODE_C;
            else if (state_reg == ST_UPDATE_IR)   ir_reg <= ir_shift_reg;
            if (state_reg == ST_CAPTURE_IR)
                ir_shift_reg <= IR_BITS'(1);
            else if (state_reg == ST_SHIFT_IR)
                ir_shift_reg <= {jtag_TDI, ir_shift_reg[IR_BITS-1:1]};
        end
    end

    // Capture value for the selected data register; unknown instructions read as BYPASS (0)
    always_comb begin
        dr_capture = '0;
        if (sel_dmi) begin
            if (pending_reg || dmistat_reg == 2'd3)
                dr_capture[1:0] = 2'b11;
            else
                dr_capture = {resp_reg[DRW-1:2],
                              (dmistat_reg == 2'd0) ? resp_reg[1:0] : dmistat_reg};
        end else if (sel_dtmcs) begin
            dr_capture[31:0] = {14'b0, 3'b0, IDLE_HINT, dmistat_reg, 6'(ABITS), 4'h1};
        end else if (sel_idcode) begin
            dr_capture[31:0] = IDCODE_VALUE;
`ifdef JTAG_DTM_USERCODE_EN
        end else if (sel_user) begin
            dr_capture[31:0] = USERCODE_VALUE;
`endif
        end
    end

    // Index of the MSB of the selected register, where TDI enters
    always_comb begin
        dr_last = 7'd0;
        if (sel_dmi)     dr_last = 7'(DRW - 1);
        else if (sel_32) dr_last = 7'd31;
    end

    // Right shift confined to the selected length; bits above it stay zero
    for (genvar gi = 0; gi < DRW; gi++) begin : g_shift
        if (gi == DRW - 1) begin : g_top
            assign dr_shifted[gi] = (7'(gi) == dr_last) ? jtag_TDI : 1'b0;
        end else begin : g_mid
            assign dr_shifted[gi] = (7'(gi) == dr_last) ? jtag_TDI :
                                    (7'(gi) > dr_last)  ? 1'b0 : dr_shift_reg[gi+1];
        end
    end

    // Data shift register: capture, then shift LSB first
    always_ff @(posedge jtag_TCK) begin
        if (!rst_n)                          dr_shift_reg <= '0;
        else if (state_reg == ST_CAPTURE_DR) dr_shift_reg <= dr_capture;
        else if (state_reg == ST_SHIFT_DR)   dr_shift_reg <= dr_shifted;
    end

    // DMI request/response tracking, sticky status and DTMCS reset controls.
    // Later statements take priority: busy over a failed response, hardreset over all.
    always_ff @(posedge jtag_TCK) begin
        if (!rst_n) begin
            dmistat_reg   <= 2'd0;
            pending_reg   <= 1'b0;
            dtm_req_valid <= 1'b0;
            dtm_req_data  <= '0;
            resp_reg      <= '0;
            dmi_hardreset <= 1'b0;
        end else begin
            dmi_hardreset <= 1'b0;
            if (dtm_req_valid && dtm_req_ready)
                dtm_req_valid <= 1'b0;
            if (dm_resp_valid && pending_reg) begin
                resp_reg    <= dm_resp_data;
                pending_reg <= 1'b0;
                if (dm_resp_data[1:0] == 2'd2 && dmistat_reg == 2'd0)
                    dmistat_reg <= 2'd2;
            end
            if (state_reg == ST_CAPTURE_DR && sel_dmi && pending_reg && dmistat_reg == 2'd0)
                dmistat_reg <= 2'd3;
            if (state_reg == ST_UPDATE_DR && sel_dmi && !pending_reg && dmistat_reg == 2'd0 &&
                (dr_shift_reg[1:0] == OP_READ || dr_shift_reg[1:0] == OP_WRITE)) begin
                dtm_req_data  <= dr_shift_reg;
                dtm_req_valid <= 1'b1;
                pending_reg   <= 1'b1;
            end
            if (state_reg == ST_UPDATE_DR && sel_dtmcs) begin
                if (dr_shift_reg[17]) begin
                    dmistat_reg   <= 2'd0;
                    pending_reg   <= 1'b0;
                    dtm_req_valid <= 1'b0;
                    dmi_hardreset <= 1'b1;
                end else if (dr_shift_reg[16]) begin
                    dmistat_reg <= 2'd0;
                end
            end
        end
    end

    // TDO launches on the falling edge so it is stable for the next rising edge
    always_ff @(negedge jtag_TCK) begin
        if (!rst_n)                        jtag_TDO <= 1'b0;
        else if (state_reg == ST_SHIFT_IR) jtag_TDO <= ir_shift_reg[0];
        else if (state_reg == ST_SHIFT_DR) jtag_TDO <= dr_shift_reg[0];
        else                               jtag_TDO <= 1'b0;
    end

endmodule

// File: tb/tb_jtag_dtm.sv
`timescale 1ns/1ps
// tb_jtag_dtm: directed scenarios plus a randomized DMI/DTMCS mix.
// Every result is compared against a transaction-level model of the DTM status.
module tb_jtag_dtm;
    localparam int IR_BITS = 5;
    localparam int ABITS   = 6;
    localparam int DRW     = ABITS + 34;
    localparam logic [IR_BITS-1:0] IR_IDCODE = 5'h01;
    localparam logic [IR_BITS-1:0] IR_DTMCS  = 5'h10;
    localparam logic [IR_BITS-1:0] IR_DMI    = 5'h11;

    logic           jtag_TCK      = 1'b0;
    logic           rst_n         = 1'b0;
    logic           jtag_TMS      = 1'b1;
    logic           jtag_TDI      = 1'b0;
    logic           jtag_TDO;
    logic           dtm_req_valid;
    logic           dtm_req_ready = 1'b0;
    logic [DRW-1:0] dtm_req_data;
    logic           dm_resp_valid = 1'b0;
    logic [DRW-1:0] dm_resp_data  = '0;
    logic           dmi_hardreset;
    logic           resp_arm      = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [1:0]     m_stat    = 2'd0;
    logic           m_pending = 1'b0;
    logic [DRW-1:0] m_resp    = '0;

    always #5 jtag_TCK = ~jtag_TCK;

    jtag_dtm #(.IR_BITS(IR_BITS), .ABITS(ABITS)) dut (
        .jtag_TCK      (jtag_TCK),
        .rst_n         (rst_n),
        .jtag_TMS      (jtag_TMS),
        .jtag_TDI      (jtag_TDI),
        .jtag_TDO      (jtag_TDO),
        .dtm_req_valid (dtm_req_valid),
        .dtm_req_ready (dtm_req_ready),
        .dtm_req_data  (dtm_req_data),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_data  (dm_resp_data),
        .dmi_hardreset (dmi_hardreset)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One TCK period. Sample TDO just after the falling edge, then set the inputs
    // that the next rising edge will see. An armed response lasts exactly one edge.
    task automatic step(input logic tms, input logic tdi, output logic tdo);
        @(negedge jtag_TCK);
        #1;
        tdo           = jtag_TDO;
        jtag_TMS      = tms;
        jtag_TDI      = tdi;
        dm_resp_valid = resp_arm;
        resp_arm      = 1'b0;
    endtask

    task automatic idle(input int n);
        logic d;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, d);
    endtask

    // Run-Test/Idle -> IR scan -> Run-Test/Idle
    task automatic scan_ir(input logic [IR_BITS-1:0] v, output logic [IR_BITS-1:0] cap);
        logic d;
        cap = '0;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        for (int i = 0; i < IR_BITS; i++) begin
            step(i == IR_BITS - 1, v[i], d);
            cap[i] = d;
        end
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    // Run-Test/Idle -> DR scan of len bits -> Run-Test/Idle (update on the next edge)
    task automatic scan_dr(input int len, input logic [DRW-1:0] v, output logic [DRW-1:0] cap);
        logic d;
        cap = '0;
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        for (int i = 0; i < len; i++) begin
            step(i == len - 1, v[i], d);
            cap[i] = d;
        end
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic select_ir(input logic [IR_BITS-1:0] v);
        logic [IR_BITS-1:0] cap;
        scan_ir(v, cap);
        check("ir_capture", 64'(cap), 64'd1);
    endtask

    function automatic logic [31:0] dtmcs_expect();
        return 32'(1 + ABITS * 16 + int'(m_stat) * 1024 + 5 * 4096);
    endfunction

    // DMI capture as the debugger sees it: busy, sticky error, or the last response
    task automatic model_dmi_capture(output logic [DRW-1:0] exp);
        exp = '0;
        if (m_pending || m_stat == 2'd3) begin
            exp[1:0] = 2'b11;
            if (m_pending && m_stat == 2'd0) m_stat = 2'd3;
        end else begin
            exp = m_resp;
            if (m_stat != 2'd0) exp[1:0] = m_stat;
        end
    endtask

    task automatic model_dmi_update(input logic [DRW-1:0] v, output bit launched);
        launched = !m_pending && m_stat == 2'd0 && (v[1:0] == 2'd1 || v[1:0] == 2'd2);
        if (launched) m_pending = 1'b1;
    endtask

    task automatic model_resp(input logic [DRW-1:0] r);
        if (m_pending) begin
            m_resp    = r;
            m_pending = 1'b0;
            if (r[1:0] == 2'd2 && m_stat == 2'd0) m_stat = 2'd2;
        end
    endtask

    // One DMI scan. wait_cycles < 0 leaves a launched request outstanding.
    task automatic dmi_scan(input logic [1:0] op, input logic [ABITS-1:0] addr,
                            input logic [31:0] data, input int wait_cycles);
        logic [DRW-1:0] v, cap, exp;
        bit launched;
        logic d;
        v = {addr, data, op};
        select_ir(IR_DMI);
        model_dmi_capture(exp);
        scan_dr(DRW, v, cap);
        check("dmi_capture", 64'(cap), 64'(exp));
        model_dmi_update(v, launched);
        $display("dmi scan op=%0d addr=%h data=%h captured=%h launched=%0d",
                 op, addr, data, cap, launched);
        if (!launched) begin
            step(1'b0, 1'b0, d);
            check("no_request", 64'(dtm_req_valid), 64'd0);
        end else if (wait_cycles < 0) begin
            step(1'b0, 1'b0, d);
            check("req_valid_open", 64'(dtm_req_valid), 64'd1);
        end else begin
            dtm_req_ready = 1'b0;
            for (int k = 0; k <= wait_cycles; k++) begin
                step(1'b0, 1'b0, d);
                check("req_valid_held", 64'(dtm_req_valid), 64'd1);
                check("req_data", 64'(dtm_req_data), 64'(v));
                if (k == wait_cycles) dtm_req_ready = 1'b1;
            end
            step(1'b0, 1'b0, d);
            check("req_valid_drop", 64'(dtm_req_valid), 64'd0);
            dtm_req_ready = 1'b0;
        end
    endtask

    task automatic dtmcs_scan(input logic [31:0] wv);
        logic [DRW-1:0] cap;
        logic [31:0] exp;
        logic d;
        select_ir(IR_DTMCS);
        exp = dtmcs_expect();
        scan_dr(32, DRW'(wv), cap);
        check("dtmcs_capture", 64'(cap[31:0]), 64'(exp));
        $display("dtmcs scan write=%h captured=%h", wv, cap[31:0]);
        if (wv[17]) begin
            m_stat    = 2'd0;
            m_pending = 1'b0;
            step(1'b0, 1'b0, d);
            check("hardreset_pulse", 64'(dmi_hardreset), 64'd1);
            check("hardreset_valid", 64'(dtm_req_valid), 64'd0);
            step(1'b0, 1'b0, d);
            check("hardreset_end", 64'(dmi_hardreset), 64'd0);
        end else begin
            if (wv[16]) m_stat = 2'd0;
            step(1'b0, 1'b0, d);
            check("hardreset_quiet", 64'(dmi_hardreset), 64'd0);
        end
    endtask

    task automatic deliver_resp(input logic [DRW-1:0] r);
        logic d;
        dm_resp_data = r;
        resp_arm     = 1'b1;
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        $display("dm response data=%h pending_before=%0d", r, m_pending);
        model_resp(r);
    endtask

    task automatic idcode_scan();
        logic [DRW-1:0] cap;
        select_ir(IR_IDCODE);
        scan_dr(32, DRW'($urandom), cap);
        check("idcode", 64'(cap[31:0]), 64'h1E200A6F);
        $display("idcode scan captured=%h", cap[31:0]);
    endtask

    task automatic bypass_scan(input logic [IR_BITS-1:0] irv);
        logic [DRW-1:0] cap, v;
        logic [7:0] exp8;
        select_ir(irv);
        v    = DRW'($urandom_range(0, 255));
        exp8 = 8'(v[7:0] << 1);
        scan_dr(8, v, cap);
        check("bypass", 64'(cap[7:0]), 64'(exp8));
        $display("bypass scan ir=%h in=%h captured=%h", irv, v[7:0], cap[7:0]);
    endtask

    initial begin
        logic d;
        logic [DRW-1:0] cap, rd;
        logic [31:0] wv;
        int act, r;

        // Reset held for two edges, then checked
        rst_n = 1'b0;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        check("rst_tdo", 64'(d), 64'd0);
        check("rst_valid", 64'(dtm_req_valid), 64'd0);
        check("rst_hardreset", 64'(dmi_hardreset), 64'd0);
        check("rst_req_data", 64'(dtm_req_data), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // IDCODE straight after reset, with no IR scan
        scan_dr(32, '0, cap);
        check("idcode_reset", 64'(cap[31:0]), 64'h1E200A6F);

        // DTMCS fixed fields
        select_ir(IR_DTMCS);
        scan_dr(32, '0, cap);
        check("dtmcs_value", 64'(cap[31:0]), 64'h00005061);
        idle(1);

        // DMI write with three cycles of back-pressure
        dmi_scan(2'd2, 6'h10, 32'h0000_0001, 3);
        deliver_resp({6'h10, 32'h0, 2'd0});

        // Busy sticky
        dmi_scan(2'd1, 6'($urandom), 32'h0, 0);
        dmi_scan(2'd1, 6'($urandom), $urandom, 0);
        dtmcs_scan(32'h0);
        rd = {6'($urandom), 32'($urandom), 2'd0};
        deliver_resp(rd);
        dtmcs_scan(32'h0001_0000);
        dtmcs_scan(32'h0);
        select_ir(IR_DMI);
        scan_dr(DRW, '0, cap);
        check("read_data_after_busy", 64'(cap), 64'(rd));

        // Failed operation blocks until dmireset
        dmi_scan(2'd1, 6'($urandom), 32'h0, 1);
        deliver_resp({6'($urandom), 32'($urandom), 2'd2});
        dmi_scan(2'd0, 6'h0, 32'h0, 0);
        dtmcs_scan(32'h0);
        dmi_scan(2'd1, 6'($urandom), 32'h0, 0);
        dtmcs_scan(32'h0001_0000);
        dmi_scan(2'd2, 6'($urandom), $urandom, 2);
        deliver_resp({6'($urandom), 32'($urandom), 2'd0});

        // Hardreset while a request is outstanding
        dmi_scan(2'd2, 6'($urandom), $urandom, -1);
        dtmcs_scan(32'h0002_0000);
        deliver_resp({6'($urandom), 32'($urandom), 2'd2});
        select_ir(IR_DMI);
        scan_dr(DRW, '0, cap);
        check("op_after_hardreset", 64'(cap[1:0]), 64'd0);
        idle(1);

        // Unlisted instructions behave as BYPASS
        bypass_scan(5'h1F);
        bypass_scan(5'h03);

        // Randomized mix against the model
        for (int it = 0; it < 40; it++) begin
            act = int'($urandom_range(0, 4));
            case (act)
                0, 1: dmi_scan(2'($urandom), 6'($urandom), $urandom,
                               int'($urandom_range(0, 3)));
                2: deliver_resp({6'($urandom), 32'($urandom),
                                 ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd2});
                3: begin
                    r  = int'($urandom_range(0, 7));
                    wv = $urandom & ~32'h0003_0000;
                    if (r < 3)            wv[16] = 1'b1;
                    if (r == 0 || r == 2) wv[17] = 1'b1;
                    dtmcs_scan(wv);
                end
                default: idcode_scan();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
